// File: rtl/analogue_pkg.sv
// Shared types and defaults for the analogue acquisition trigger path.
package analogue_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH  = 8;
  localparam int unsigned DEF_HOLDOFF_WIDTH = 16;
  localparam int unsigned DEF_AUTO_WIDTH    = 20;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREARM  = 2'd1,
    ARMED   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/analogue_trigger_compare.sv
// Saturating hysteresis band plus arm/fire comparisons for one sample.
module analogue_trigger_compare
  import analogue_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
  input  logic                    slope,
  input  logic [SAMPLE_WIDTH-1:0] level,
  input  logic [SAMPLE_WIDTH-1:0] hysteresis,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    arm_hit_c,
  output logic                    fire_hit_c
);

  localparam int unsigned EXT_WIDTH = SAMPLE_WIDTH + 1;

  logic [EXT_WIDTH-1:0]    diff_c;
  logic [EXT_WIDTH-1:0]    sum_c;
  logic [SAMPLE_WIDTH-1:0] lo_c;
  logic [SAMPLE_WIDTH-1:0] hi_c;
  logic                    hyst_zero_c;

  // Band edges with one guard bit so under/overflow saturates instead of wrapping
  always_comb begin
    diff_c      = EXT_WIDTH'(level) - EXT_WIDTH'(hysteresis);
    sum_c       = EXT_WIDTH'(level) + EXT_WIDTH'(hysteresis);
    lo_c        = diff_c[SAMPLE_WIDTH] ? '0 : diff_c[SAMPLE_WIDTH-1:0];
    hi_c        = sum_c[SAMPLE_WIDTH]  ? '1 : sum_c[SAMPLE_WIDTH-1:0];
    hyst_zero_c = (hysteresis == '0);
    arm_hit_c   = 1'b0;
    fire_hit_c  = 1'b0;
    if (slope == SLOPE_RISING) begin
      arm_hit_c  = (sample < lo_c) || (hyst_zero_c && (sample < level));
      fire_hit_c = (sample >= level);
    end else begin
      arm_hit_c  = (sample > hi_c) || (hyst_zero_c && (sample > level));
      fire_hit_c = (sample <= level);
    end
  end

endmodule

// File: rtl/analogue_edge_trigger.sv
// Level-crossing trigger with hysteresis re-arm and holdoff.
// Optional auto-trigger timeout enabled by defining ANALOGUE_TRIGGER_AUTO_EN.
module analogue_edge_trigger
  import analogue_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
  parameter int unsigned HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH,
  parameter int unsigned AUTO_WIDTH    = DEF_AUTO_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample,
  input  logic                     arm,
  input  logic                     slope,
  input  logic [SAMPLE_WIDTH-1:0]  level,
  input  logic [SAMPLE_WIDTH-1:0]  hysteresis,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic [AUTO_WIDTH-1:0]    auto_timeout,
  output logic                     armed,
  output logic                     trigger,
  output logic                     trigger_auto
);

  state_t                   state;
  state_t                   state_d;
  logic                     cfg_slope;
  logic [SAMPLE_WIDTH-1:0]  cfg_level;
  logic [SAMPLE_WIDTH-1:0]  cfg_hyst;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;
  logic                     arm_hit_c;
  logic                     fire_hit_c;
  logic                     real_fire_c;
  logic                     auto_hit_c;
  logic                     in_window_c;
  logic                     armed_d;
  logic                     trigger_d;

  analogue_trigger_compare #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_compare (
    .slope      (cfg_slope),
    .level      (cfg_level),
    .hysteresis (cfg_hyst),
    .sample     (sample),
    .arm_hit_c  (arm_hit_c),
    .fire_hit_c (fire_hit_c)
  );

  assign in_window_c = (state == PREARM) || (state == ARMED);
  assign real_fire_c = arm && (state == ARMED) && sample_valid && fire_hit_c;

`ifdef ANALOGUE_TRIGGER_AUTO_EN
  localparam int unsigned AUTO_EXT_WIDTH = AUTO_WIDTH + 1;

  logic [AUTO_WIDTH-1:0]     auto_cnt;
  logic [AUTO_EXT_WIDTH-1:0] auto_inc_c;
  logic                      trigger_auto_d;

  assign auto_inc_c = AUTO_EXT_WIDTH'(auto_cnt) + AUTO_EXT_WIDTH'(1);
  assign auto_hit_c = arm && in_window_c && (auto_timeout != '0) &&
                      (auto_inc_c == AUTO_EXT_WIDTH'(auto_timeout));

  // Timeout counter: restarts on every entry to PREARM, runs while waiting for a crossing
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if ((state_d == PREARM) && (state != PREARM)) begin
      auto_cnt <= '0;
    end else if (in_window_c && (auto_cnt != '1)) begin
      auto_cnt <= auto_cnt + AUTO_WIDTH'(1);
    end
  end

  // Forced-trigger flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      trigger_auto <= 1'b0;
    end else begin
      trigger_auto <= trigger_auto_d;
    end
  end
`else
  logic unused_auto;
  assign unused_auto  = ^auto_timeout;
  assign auto_hit_c   = 1'b0;
  assign trigger_auto = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; disarm overrides any sample or timeout in the same cycle
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (arm) state_d = PREARM;
      end
      PREARM: begin
        if (!arm)                            state_d = IDLE;
        else if (auto_hit_c)                 state_d = HOLDOFF;
        else if (sample_valid && arm_hit_c)  state_d = ARMED;
      end
      ARMED: begin
        if (!arm)                            state_d = IDLE;
        else if (real_fire_c || auto_hit_c)  state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (!arm)                            state_d = IDLE;
        else if (hold_cnt == holdoff)        state_d = PREARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    armed_d   = (state_d == ARMED);
    trigger_d = real_fire_c || auto_hit_c;
`ifdef ANALOGUE_TRIGGER_AUTO_EN
    trigger_auto_d = auto_hit_c && !real_fire_c;
`endif
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      trigger <= 1'b0;
    end else begin
      armed   <= armed_d;
      trigger <= trigger_d;
    end
  end

  // Configuration snapshot taken only when leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_slope <= SLOPE_RISING;
      cfg_level <= '0;
      cfg_hyst  <= '0;
    end else if ((state == IDLE) && arm) begin
      cfg_slope <= slope;
      cfg_level <= level;
      cfg_hyst  <= hysteresis;
    end
  end

  // Holdoff counter: clears on entry, counts valid samples, saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((state_d == HOLDOFF) && (state != HOLDOFF)) begin
      hold_cnt <= '0;
    end else if ((state == HOLDOFF) && sample_valid && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + HOLDOFF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_analogue_edge_trigger.sv
// Directed bench for analogue_edge_trigger; auto-trigger checks follow ANALOGUE_TRIGGER_AUTO_EN.
module tb_analogue_edge_trigger;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        arm;
  logic        slope;
  logic [7:0]  level;
  logic [7:0]  hysteresis;
  logic [15:0] holdoff;
  logic [19:0] auto_timeout;
  logic        armed;
  logic        trigger;
  logic        trigger_auto;

  int checks   = 0;
  int failures = 0;

  analogue_edge_trigger dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .arm          (arm),
    .slope        (slope),
    .level        (level),
    .hysteresis   (hysteresis),
    .holdoff      (holdoff),
    .auto_timeout (auto_timeout),
    .armed        (armed),
    .trigger      (trigger),
    .trigger_auto (trigger_auto)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_armed", 32'(armed), 0);
    check("reset_trigger", 32'(trigger), 0);
    check("reset_trigger_auto", 32'(trigger_auto), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input logic s, input logic [7:0] lv, input logic [7:0] hy,
                       input logic [15:0] ho, input logic [19:0] at);
    @(negedge clk);
    slope = s; level = lv; hysteresis = hy; holdoff = ho; auto_timeout = at;
    arm = 1'b1; sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] s);
    @(negedge clk);
    sample_valid = v; sample = s;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fall_seq [8] = '{70, 60, 70, 60, 70, 60, 70, 60};
  logic       fall_trg [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
  logic       fall_arm [8] = '{1, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = '0;
    slope = 1'b0; level = '0; hysteresis = '0; holdoff = '0; auto_timeout = '0;

    // Rising crossing with noise rejection
    do_reset();
    start(1'b0, 8'd128, 8'd8, 16'd0, 20'd0);
    push(1'b1, 8'd100);
    check("rise_armed_after_100", 32'(armed), 1);
    check("rise_no_trig_100", 32'(trigger), 0);
    push(1'b1, 8'd130);
    check("rise_trig_130", 32'(trigger), 1);
    check("rise_disarmed_130", 32'(armed), 0);
    push(1'b1, 8'd125);
    check("rise_single_pulse", 32'(trigger), 0);
    push(1'b1, 8'd129);
    check("noise_no_trig_129", 32'(trigger), 0);
    check("noise_not_armed_129", 32'(armed), 0);
    push(1'b1, 8'd119);
    check("noise_rearm_119", 32'(armed), 1);
    push(1'b1, 8'd128);
    check("noise_trig_128", 32'(trigger), 1);

    // Falling with holdoff of three valid samples
    do_reset();
    start(1'b1, 8'd64, 8'd4, 16'd3, 20'd0);
    for (int i = 0; i < 8; i++) begin
      push(1'b1, fall_seq[i]);
      check($sformatf("fall_trig_%0d", i), 32'(trigger), 32'(fall_trg[i]));
      check($sformatf("fall_armed_%0d", i), 32'(armed), 32'(fall_arm[i]));
    end

    // Config changes while armed are ignored, then abort beats a crossing
    do_reset();
    start(1'b0, 8'd128, 8'd8, 16'd0, 20'd0);
    push(1'b1, 8'd100);
    level = 8'd250;
    push(1'b1, 8'd130);
    check("latched_level_trig", 32'(trigger), 1);
    push(1'b0, 8'd0);
    push(1'b1, 8'd100);
    check("abort_pre_armed", 32'(armed), 1);
    @(negedge clk);
    arm = 1'b0; sample_valid = 1'b1; sample = 8'd200;
    @(posedge clk);
    #1;
    check("abort_no_trig", 32'(trigger), 0);
    check("abort_armed_low", 32'(armed), 0);
    push(1'b1, 8'd100);
    push(1'b1, 8'd200);
    check("idle_no_trig", 32'(trigger), 0);
    check("idle_not_armed", 32'(armed), 0);

    // Threshold saturation and extreme levels
    do_reset();
    start(1'b0, 8'd5, 8'd10, 16'd0, 20'd0);
    push(1'b1, 8'd0);
    check("sat_lo_no_arm", 32'(armed), 0);
    push(1'b1, 8'd200);
    check("sat_lo_no_trig", 32'(trigger), 0);
    do_reset();
    start(1'b1, 8'd250, 8'd10, 16'd0, 20'd0);
    push(1'b1, 8'd255);
    check("sat_hi_no_arm", 32'(armed), 0);
    push(1'b1, 8'd0);
    check("sat_hi_no_trig", 32'(trigger), 0);
    do_reset();
    start(1'b0, 8'd0, 8'd0, 16'd0, 20'd0);
    push(1'b1, 8'd0);
    check("level0_no_arm", 32'(armed), 0);

    // Zero hysteresis arms just below level
    do_reset();
    start(1'b0, 8'd128, 8'd0, 16'd0, 20'd0);
    push(1'b1, 8'd127);
    check("hyst0_armed", 32'(armed), 1);
    push(1'b1, 8'd128);
    check("hyst0_trig", 32'(trigger), 1);

    // Auto-trigger timeout with a level that is never crossed
    do_reset();
    start(1'b0, 8'd128, 8'd8, 16'd0, 20'd50);
    for (int i = 1; i <= 60; i++) begin
      push(1'b1, 8'd100);
`ifdef ANALOGUE_TRIGGER_AUTO_EN
      check($sformatf("auto_trig_%0d", i), 32'(trigger), 32'(i == 50));
      check($sformatf("auto_flag_%0d", i), 32'(trigger_auto), 32'(i == 50));
`else
      check($sformatf("auto_trig_%0d", i), 32'(trigger), 0);
      check($sformatf("auto_flag_%0d", i), 32'(trigger_auto), 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/analogue_edge_trigger.md
Name: analogue_edge_trigger

Overview:
- Downstream consumer of the analogue decimation stage inside the analogue acquisition path.
- Watches the decimated sample stream and raises a one-cycle trigger pulse on a qualified rising or falling crossing of a programmable level.
- Hysteresis rejects noise; holdoff suppresses re-triggering.
- Drives the acquisition block's trigger output.

Parameters:
SAMPLE_WIDTH, 8, bit width of decimated samples, level and hysteresis
HOLDOFF_WIDTH, 16, bit width of holdoff counter, in valid-sample units
AUTO_WIDTH, 20, bit width of auto-trigger timeout counter, in clk cycles; only used with ANALOGUE_TRIGGER_AUTO_EN

Ports:
clk  in  1  system clock; one clock
rst  in  1  reset; synchronous, active-high
sample_valid  in  1  qualifies sample, from decimator
sample  in  SAMPLE_WIDTH  unsigned decimated sample
arm  in  1  level enable; low forces IDLE
slope  in  1  0 = rising, 1 = falling
level  in  SAMPLE_WIDTH  trigger threshold
hysteresis  in  SAMPLE_WIDTH  re-arm band width
holdoff  in  HOLDOFF_WIDTH  valid samples ignored after a trigger
auto_timeout  in  AUTO_WIDTH  clk cycles before forced trigger; 0 = disabled (feature builds only)
armed  out  1  high in ARMED state
trigger  out  1  one-cycle pulse per trigger event
trigger_auto  out  1  one-cycle pulse, coincident with trigger, when the trigger was forced; tied 0 without the feature

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state = IDLE; armed = 0, trigger = 0, trigger_auto = 0; counters = 0.
- Latched configuration:
  - slope, level and hysteresis are captured on the IDLE->PREARM transition.
  - Changes made while armed have no effect until the next pass through IDLE.
- Band thresholds, computed once at capture, SAMPLE_WIDTH+1 internal arithmetic:
  - Rising: lo = level - hysteresis, saturated at 0.
  - Falling: hi = level + hysteresis, saturated at 2^SAMPLE_WIDTH-1.
- States:
  - IDLE: wait for arm = 1, then latch configuration and go to PREARM.
  - PREARM: on a valid sample, go to ARMED if
    - rising: sample < lo, or hysteresis = 0 and sample < level;
    - falling: sample > hi, or hysteresis = 0 and sample > level.
  - ARMED: on a valid sample with (rising: sample >= level) or (falling: sample <= level), pulse trigger and go to HOLDOFF.
  - HOLDOFF: count valid samples. When count = holdoff, go to PREARM. holdoff = 0 means the next cycle goes directly to PREARM.
- Latency: trigger is registered and asserts on the clk edge after the qualifying sample_valid cycle. trigger is never high on consecutive cycles.
- armed is registered and tracks state == ARMED.
- Invalid cycles: samples with sample_valid = 0 are ignored in all states.
- Abort: arm = 0 in any non-IDLE state goes to IDLE on the next edge, and no trigger is issued on that edge. Abort beats a simultaneous qualifying sample.
- Reset wins over all other inputs.
- Level at extremes:
  - rising with level = 0 can never reach ARMED (nothing is < 0);
  - falling with level = max can never reach ARMED;
  - both are legal and simply never trigger.
- Holdoff counter saturates; it never wraps.

Optional Feature:
ANALOGUE_TRIGGER_AUTO_EN
- Defined:
  - A clk-cycle counter runs in PREARM and ARMED; it clears on entry to PREARM.
  - When auto_timeout != 0 and count reaches auto_timeout, trigger and trigger_auto pulse together and the state goes to HOLDOFF.
  - A real crossing in the same cycle takes priority: trigger only, trigger_auto = 0.
- Undefined: no counter, auto_timeout is ignored, trigger_auto is tied to 0.

Decomposition:
- Shared package analogue_pkg:
  - state encoding constants IDLE/PREARM/ARMED/HOLDOFF;
  - slope constants SLOPE_RISING = 0, SLOPE_FALLING = 1;
  - default width constants.
- Sub-module analogue_trigger_compare: combinational saturating threshold calculation plus the arm/fire comparison, parameterised by SAMPLE_WIDTH, instantiated once.

Test Plan:
- Rising, level = 128, hysteresis = 8, holdoff = 0; valid samples 100, 130 -> armed after 100; trigger 1 cycle after the 130 sample; single pulse.
- Noise rejection, rising, level = 128, hysteresis = 8, holdoff = 0; samples 100, 130, 125, 129 -> exactly one trigger (125 is not < 120, so no re-arm); adding 119, 128 -> second trigger.
- Falling, level = 64, hysteresis = 4, holdoff = 3; samples 70, 60, then 70, 60 repeated -> first trigger on the first 60; next 3 valid samples ignored; re-arm follows.
- Abort: armed, then arm = 0 in the same cycle as qualifying sample 200 (level = 128) -> no trigger, IDLE next edge, armed = 0.
- Saturation: rising, level = 5, hysteresis = 10 -> lo = 0, never arms; falling, level = 250, hysteresis = 10 -> hi = 255, sample 255 does not arm.
- With ANALOGUE_TRIGGER_AUTO_EN, auto_timeout = 50, constant sample 100, level = 128 -> trigger and trigger_auto both pulse 50 cycles after PREARM entry. Without the macro -> no trigger ever, trigger_auto stays 0.
